lut_layer_engine: RTL and testbench

LUT_LAYER_ENGINE -- requirements
Module: lut_layer_engine

---
 rtl/lut_layer_engine_pkg.sv | 15 +
 rtl/lut_neuron_table.sv | 47 ++++
 rtl/lut_layer_engine.sv | 128 ++++++++++++
 tb/tb_lut_layer_engine.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_layer_engine_pkg.sv
// Shared types and helpers for the truth-table layer engine.
package lut_layer_engine_pkg;

    typedef enum logic [1:0] {
        ST_UNLOADED = 2'd0,
        ST_LOAD     = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    // Width of a neuron index; a single-neuron layer still needs one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// One neuron's truth table: distributed RAM plus per-entry written flags.
// Latency: synchronous write, combinational read.
// Backpressure: none; the write port is always ready.
module lut_neuron_table
    import lut_layer_engine_pkg::*;
#(
    parameter int FAN_IN_BITS = 6,
    parameter int OUT_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   we,
    input  logic [FAN_IN_BITS-1:0] waddr,
    input  logic [OUT_BITS-1:0]    wdata,
    input  logic [FAN_IN_BITS-1:0] raddr,
    output logic [OUT_BITS-1:0]    rdata
);

    localparam int DEPTH = 1 << FAN_IN_BITS;

    logic [OUT_BITS-1:0] mem [DEPTH];
    logic [DEPTH-1:0]    ent_vld;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A clear and a write in the same cycle leave only the new entry marked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld <= '0;
        end else begin
            if (clr) begin
                ent_vld <= '0;
            end
            if (we) begin
                ent_vld[waddr] <= 1'b1;
            end
        end
    end

    assign rdata = ent_vld[raddr] ? mem[raddr] : '0;

endmodule

// File: rtl/lut_layer_engine.sv
// Layer of N_NEURONS truth-table neurons with a runtime table-load port.
// Latency: 2 cycles (S1 captures addresses, S2 captures table outputs), 1 beat/cycle.
// Backpressure: both stages stall together while out_valid && !out_ready.
module lut_layer_engine
    import lut_layer_engine_pkg::*;
#(
    parameter int N_NEURONS   = 8,
    parameter int FAN_IN_BITS = 6,
    parameter int OUT_BITS    = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_valid,
    input  logic [idx_bits(N_NEURONS)-1:0]   cfg_neuron,
    input  logic [FAN_IN_BITS-1:0]           cfg_addr,
    input  logic [OUT_BITS-1:0]              cfg_data,
    input  logic                             cfg_done,
    output logic                             cfg_err,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N_NEURONS*FAN_IN_BITS-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0]    out_data,
    output logic                             loaded
);

    localparam int NW = idx_bits(N_NEURONS);
    localparam int IW = N_NEURONS * FAN_IN_BITS;
    localparam int OW = N_NEURONS * OUT_BITS;
    localparam logic [NW:0] N_LIM = (NW+1)'(N_NEURONS);

    state_t          state;
    logic            s1_vld;
    logic [IW-1:0]   s1_dat;
    logic [OW-1:0]   lut_rd;
    logic            advance;
    logic            accept;
    logic            pipe_busy;
    logic            nrn_bad;
    logic            cfg_take;
    logic            wr_en;
    logic            tbl_clr;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = (state == ST_RUN) && advance;
    assign accept    = in_valid && in_ready;
    assign pipe_busy = s1_vld || out_valid;
    assign nrn_bad   = {1'b0, cfg_neuron} >= N_LIM;

    // A config access is taken unless it would disturb beats still in flight.
    assign cfg_take = cfg_valid && !((state == ST_RUN) && pipe_busy);
    assign wr_en    = cfg_take && !nrn_bad;
    assign tbl_clr  = cfg_valid && (state == ST_UNLOADED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_UNLOADED;
            loaded  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_valid && (nrn_bad || !cfg_take);
            unique case (state)
                ST_UNLOADED: begin
                    if (cfg_valid) begin
                        state  <= ST_LOAD;
                        loaded <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (cfg_done) begin
                        state  <= ST_RUN;
                        loaded <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cfg_take) begin
                        state  <= ST_LOAD;
                        loaded <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_UNLOADED;
                    loaded <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_dat    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            s1_vld    <= accept;
            if (accept) begin
                s1_dat <= in_data;
            end
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_data <= lut_rd;
            end
        end
    end

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_nrn
        logic nrn_we;

        assign nrn_we = wr_en && (cfg_neuron == NW'(i));

        lut_neuron_table #(
            .FAN_IN_BITS (FAN_IN_BITS),
            .OUT_BITS    (OUT_BITS)
        ) u_tbl (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (tbl_clr),
            .we    (nrn_we),
            .waddr (cfg_addr),
            .wdata (cfg_data),
            .raddr (s1_dat[i*FAN_IN_BITS +: FAN_IN_BITS]),
            .rdata (lut_rd[i*OUT_BITS +: OUT_BITS])
        );
    end

endmodule

// File: tb/tb_lut_layer_engine.sv
// Bench for lut_layer_engine: default layer plus 16- and 1-neuron variants.
`timescale 1ns/1ps
module tb_lut_layer_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- default instance: 8 neurons, 6-bit address, 1-bit out
    logic        cfg_valid = 1'b0, cfg_done = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0]  cfg_neuron = '0;
    logic [5:0]  cfg_addr = '0;
    logic [0:0]  cfg_data = '0;
    logic [47:0] in_data = '0;
    logic        cfg_err, in_ready, out_valid, loaded;
    logic [7:0]  out_data;

    lut_layer_engine u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_neuron(cfg_neuron),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .loaded(loaded)
    );

    // ---------------- sweep instances: 16 and 1 neurons, 4-bit address, 2-bit out
    logic        sw_cfg_valid = 1'b0, sw_cfg_done = 1'b0, sw_in_valid = 1'b0, sw_out_ready = 1'b0;
    logic        n1_cfg_valid = 1'b0;
    logic [3:0]  sw_cfg_neuron = '0, sw_cfg_addr = '0;
    logic [1:0]  sw_cfg_data = '0;
    logic [0:0]  n1_cfg_neuron = '0;
    logic [63:0] sw_in_data = '0;
    logic        s16_cfg_err, s16_in_ready, s16_out_valid, s16_loaded;
    logic [31:0] s16_out_data;
    logic        s1_cfg_err, s1_in_ready, s1_out_valid, s1_loaded;
    logic [1:0]  s1_out_data;

    lut_layer_engine #(.N_NEURONS(16), .FAN_IN_BITS(4), .OUT_BITS(2)) u_s16 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(sw_cfg_valid), .cfg_neuron(sw_cfg_neuron),
        .cfg_addr(sw_cfg_addr), .cfg_data(sw_cfg_data), .cfg_done(sw_cfg_done), .cfg_err(s16_cfg_err),
        .in_valid(sw_in_valid), .in_ready(s16_in_ready), .in_data(sw_in_data),
        .out_valid(s16_out_valid), .out_ready(sw_out_ready), .out_data(s16_out_data), .loaded(s16_loaded)
    );

    lut_layer_engine #(.N_NEURONS(1), .FAN_IN_BITS(4), .OUT_BITS(2)) u_s1 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(n1_cfg_valid), .cfg_neuron(n1_cfg_neuron),
        .cfg_addr(sw_cfg_addr), .cfg_data(sw_cfg_data), .cfg_done(sw_cfg_done), .cfg_err(s1_cfg_err),
        .in_valid(sw_in_valid), .in_ready(s1_in_ready), .in_data(sw_in_data[3:0]),
        .out_valid(s1_out_valid), .out_ready(sw_out_ready), .out_data(s1_out_data), .loaded(s1_loaded)
    );

    // ---------------- reference model
    typedef enum {M_UNL, M_LOAD, M_RUN} mstate_t;
    mstate_t     m_state = M_UNL;
    bit          m_tab [8][64];
    bit          m_wr  [8][64];
    logic [7:0]  m_q[$];
    bit          m_err = 1'b0;
    int          m_pops = 0;
    logic [1:0]  sw_tab [16][16];
    logic [31:0] sw_q[$];
    int          sw_pops = 0;

    function automatic logic [7:0] m_lookup(input logic [47:0] d);
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = m_wr[i][d[i*6 +: 6]] ? m_tab[i][d[i*6 +: 6]] : 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] sw_lookup(input logic [63:0] d);
        logic [31:0] r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i*2 +: 2] = sw_tab[i][d[i*4 +: 4]];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_UNL;
            m_err   = 1'b0;
            m_q.delete();
            sw_q.delete();
        end else begin
            mstate_t st;
            st    = m_state;
            m_err = 1'b0;
            if (in_valid && in_ready) m_q.push_back(m_lookup(in_data));
            if (out_valid && out_ready) begin
                if (m_q.size() != 0) void'(m_q.pop_front());
                m_pops++;
            end
            if (cfg_valid) begin
                if (st == M_RUN && m_q.size() != 0) begin
                    m_err = 1'b1;
                end else begin
                    if (st == M_UNL) begin
                        for (int n = 0; n < 8; n++)
                            for (int a = 0; a < 64; a++) m_wr[n][a] = 1'b0;
                    end
                    m_tab[cfg_neuron][cfg_addr] = cfg_data[0];
                    m_wr[cfg_neuron][cfg_addr]  = 1'b1;
                    if (st != M_LOAD) m_state = M_LOAD;
                end
            end
            if (st == M_LOAD && cfg_done) m_state = M_RUN;
            if (sw_in_valid && s16_in_ready) sw_q.push_back(sw_lookup(sw_in_data));
            if (s16_out_valid && sw_out_ready) begin
                if (sw_q.size() != 0) void'(sw_q.pop_front());
                sw_pops++;
            end
        end
    end

    // ---------------- compare process
    logic [7:0] prev_dat = '0;
    bit         prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_data", out_data, 8'h00);
            check("rst_in_ready", in_ready, 1'b0);
            check("rst_cfg_err", cfg_err, 1'b0);
            check("rst_loaded", loaded, 1'b0);
            prev_stall = 1'b0;
        end else begin
            check("cfg_err", cfg_err, m_err);
            check("loaded", loaded, m_state == M_RUN);
            check("in_ready", in_ready, (m_state == M_RUN) && (!out_valid || out_ready));
            if (out_valid) begin
                check("beat_pending", m_q.size() != 0, 1'b1);
                if (m_q.size() != 0) check("out_data", out_data, m_q[0]);
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, prev_dat);
            end
            prev_stall = out_valid && !out_ready;
            prev_dat   = out_data;
            check("sw_valid_match", s1_out_valid, s16_out_valid);
            check("sw_ready_match", s1_in_ready, s16_in_ready);
            if (s16_out_valid) begin
                check("sw_beat_pending", sw_q.size() != 0, 1'b1);
                if (sw_q.size() != 0) begin
                    check("sw16_out_data", s16_out_data, sw_q[0]);
                    check("sw1_out_data", s1_out_data, sw_q[0][1:0]);
                end
            end
        end
    end

    // ---------------- stimulus helpers
    int alist[8];

    function automatic logic [47:0] rand48();
        logic [47:0] d = '0;
        for (int i = 0; i < 8; i++) d[i*6 +: 6] = 6'(alist[$urandom_range(0, 7)]);
        return d;
    endfunction

    task automatic cfg_set(input int n, input int a, input bit d, input bit done);
        @(posedge clk); #1;
        cfg_valid  = 1'b1;
        cfg_neuron = 3'(n);
        cfg_addr   = 6'(a);
        cfg_data   = d;
        cfg_done   = done;
    endtask

    task automatic cfg_idle();
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_done  = 1'b0;
    endtask

    task automatic send_get(input logic [47:0] d, output logic [7:0] r, output bit got);
        got = 1'b0;
        r   = '0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                r   = out_data;
            end
        end
    endtask

    task automatic drain_main(input string name);
        bit idle = 1'b0;
        for (int k = 0; k < 40 && !idle; k++) begin
            @(negedge clk);
            idle = (m_q.size() == 0) && !out_valid;
        end
        check(name, idle, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          hs, got;
        int          sent, pops0;
        logic [7:0]  r;
        logic [47:0] d;
        logic [47:0] beats[16];

        alist = '{36, 44, 34, 63, 0, 9, 5, 17};
        for (int n = 0; n < 16; n++)
            for (int a = 0; a < 16; a++) sw_tab[n][a] = 2'b00;

        // reset state and UNLOADED behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = rand48();
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("unloaded_in_ready", in_ready, 1'b0);
            check("unloaded_out_valid", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // load session; last write coincides with cfg_done
        cfg_set(0, 36, 1'b1, 1'b0);
        cfg_set(0, 44, 1'b1, 1'b0);
        cfg_set(0, 34, 1'b1, 1'b0);
        cfg_set(0, 63, 1'b1, 1'b0);
        cfg_set(0, 0, 1'b0, 1'b0);
        cfg_set(5, 9, 1'b1, 1'b0);
        cfg_set(7, 0, 1'b1, 1'b0);
        cfg_set(3, 5, 1'b1, 1'b1);
        cfg_idle();
        @(negedge clk);
        check("loaded_after_done", loaded, 1'b1);
        @(posedge clk); #1;
        cfg_done = 1'b1;
        @(posedge clk); #1;
        cfg_done = 1'b0;
        @(negedge clk);
        check("done_in_run_loaded", loaded, 1'b1);

        // two-cycle latency, addresses 100100 then 000000
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 48'h0;
        in_data[5:0] = 6'b100100;
        @(negedge clk);
        check("lat_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_data = 48'h0;
        @(negedge clk);
        check("lat_not_early", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_beat0_valid", out_valid, 1'b1);
        check("lat_beat0_n0", out_data[0], 1'b1);
        check("lat_beat0_all", out_data, 8'h81);
        @(negedge clk);
        check("lat_beat1_valid", out_valid, 1'b1);
        check("lat_beat1_n0", out_data[0], 1'b0);
        check("lat_beat1_all", out_data, 8'h80);
        d = '0;
        d[5:0] = 6'd63; d[23:18] = 6'd5; d[35:30] = 6'd9; d[47:42] = 6'd1;
        send_get(d, r, got);
        check("mixed_got", got, 1'b1);
        check("mixed_value", r, 8'h29);
        drain_main("drain_after_latency");

        // 16 back-to-back beats with out_ready toggling every cycle
        for (int i = 0; i < 16; i++) beats[i] = rand48();
        pops0 = m_pops;
        sent  = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = beats[0];
        for (int cyc = 0; cyc < 200 && sent < 16; cyc++) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            out_ready = ~out_ready;
            if (hs) begin
                sent++;
                if (sent < 16) in_data = beats[sent];
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        drain_main("drain_after_stream");
        check("stream_sent", sent, 16);
        check("stream_outputs", m_pops - pops0, 16);

        // cfg access with a beat in S1 is rejected; after drain it reopens LOAD
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 48'h0;
        in_data[5:0] = 6'b100100;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        cfg_valid  = 1'b1;
        cfg_neuron = 3'd0;
        cfg_addr   = 6'd36;
        cfg_data   = 1'b0;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        check("busy_cfg_err", cfg_err, 1'b1);
        check("busy_loaded", loaded, 1'b1);
        check("busy_beat_n0", out_data[0], 1'b1);
        @(negedge clk);
        check("busy_err_one_cycle", cfg_err, 1'b0);
        drain_main("drain_after_busy");
        cfg_set(1, 2, 1'b1, 1'b0);
        cfg_idle();
        @(negedge clk);
        check("reload_no_err", cfg_err, 1'b0);
        check("reload_state_load", loaded, 1'b0);
        @(posedge clk); #1;
        cfg_done = 1'b1;
        @(posedge clk); #1;
        cfg_done = 1'b0;
        d = '0;
        d[5:0] = 6'd36; d[11:6] = 6'd2;
        send_get(d, r, got);
        check("reload_got", got, 1'b1);
        check("reload_value", r, 8'h83);
        drain_main("drain_after_reload");

        // asynchronous reset with two beats in flight
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = rand48();
        @(posedge clk); #1;
        in_data = rand48();
        @(posedge clk); #1;
        check("inflight_valid", out_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b0);
        check("arst_loaded", loaded, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_done = 1'b1;
        @(posedge clk); #1;
        cfg_done = 1'b0;
        @(negedge clk);
        check("done_in_unloaded", loaded, 1'b0);
        check("done_in_unloaded_rdy", in_ready, 1'b0);
        cfg_set(2, 7, 1'b1, 1'b0);
        cfg_idle();
        @(negedge clk);
        check("load_not_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        cfg_done = 1'b1;
        @(posedge clk); #1;
        cfg_done = 1'b0;
        d = '0;
        d[5:0] = 6'd36; d[17:12] = 6'd7;
        send_get(d, r, got);
        check("post_rst_got", got, 1'b1);
        check("post_rst_value", r, 8'h04);
        drain_main("drain_after_reset");

        // out-of-range neuron index on the single-neuron layer
        @(posedge clk); #1;
        n1_cfg_valid  = 1'b1;
        n1_cfg_neuron = 1'b1;
        sw_cfg_addr   = 4'd3;
        sw_cfg_data   = 2'd3;
        @(posedge clk); #1;
        n1_cfg_valid = 1'b0;
        @(negedge clk);
        check("bad_nrn_err", s1_cfg_err, 1'b1);
        check("bad_nrn_other_err", s16_cfg_err, 1'b0);
        @(negedge clk);
        check("bad_nrn_err_pulse", s1_cfg_err, 1'b0);

        // random tables, entry (0,3) left unwritten in both layers
        for (int n = 0; n < 16; n++) begin
            for (int a = 0; a < 16; a++) begin
                if (!(n == 0 && a == 3)) begin
                    @(posedge clk); #1;
                    sw_cfg_valid  = 1'b1;
                    n1_cfg_valid  = (n == 0);
                    n1_cfg_neuron = 1'b0;
                    sw_cfg_neuron = 4'(n);
                    sw_cfg_addr   = 4'(a);
                    sw_cfg_data   = 2'($urandom_range(0, 3));
                    sw_tab[n][a]  = sw_cfg_data;
                end
            end
        end
        @(posedge clk); #1;
        sw_cfg_valid = 1'b0;
        n1_cfg_valid = 1'b0;
        sw_cfg_done  = 1'b1;
        @(posedge clk); #1;
        sw_cfg_done = 1'b0;
        @(negedge clk);
        check("sw16_loaded", s16_loaded, 1'b1);
        check("sw1_loaded", s1_loaded, 1'b1);

        pops0 = sw_pops;
        sent  = 0;
        sw_in_data = {$urandom, $urandom};
        for (int cyc = 0; cyc < 8000 && sent < 1000; cyc++) begin
            @(negedge clk);
            hs = sw_in_valid && s16_in_ready;
            @(posedge clk); #1;
            if (hs) begin
                sent++;
                sw_in_data = {$urandom, $urandom};
            end
            sw_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            sw_out_ready = ($urandom_range(0, 9) < 7);
        end
        sw_in_valid  = 1'b0;
        sw_out_ready = 1'b1;
        begin
            bit idle = 1'b0;
            for (int k = 0; k < 40 && !idle; k++) begin
                @(negedge clk);
                idle = (sw_q.size() == 0) && !s16_out_valid;
            end
            check("sweep_drained", idle, 1'b1);
        end
        check("sweep_sent", sent, 1000);
        check("sweep_outputs", sw_pops - pops0, 1000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
